// File: rtl/op_decode_pkg.sv
// op_decode_pkg: field layout, encodings and the combinational decode
// function shared by the op_decode register stage.
package op_decode_pkg;

  localparam int OPC_HI = 20;
  localparam int OPC_LO = 17;
  localparam int SRC_HI = 16;
  localparam int SRC_LO = 14;
  localparam int DST_HI = 13;
  localparam int DST_LO = 11;
  localparam int IMM_HI = 10;
  localparam int IMM_LO = 0;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_MOV = 4'd1,
    OP_SWP = 4'd2,
    OP_SAV = 4'd3,
    OP_ADD = 4'd4,
    OP_SUB = 4'd5,
    OP_NEG = 4'd6,
    OP_JMP = 4'd7,
    OP_JEZ = 4'd8,
    OP_JNZ = 4'd9,
    OP_JGZ = 4'd10,
    OP_JLZ = 4'd11,
    OP_JRO = 4'd12
  } opcode_e;

  typedef enum logic [2:0] {
    OPD_IMM   = 3'd0,
    OPD_ACC   = 3'd1,
    OPD_NIL   = 3'd2,
    OPD_UP    = 3'd3,
    OPD_DOWN  = 3'd4,
    OPD_LEFT  = 3'd5,
    OPD_RIGHT = 3'd6,
    OPD_ANY   = 3'd7
  } operand_e;

  typedef enum logic [3:0] {
    PC_INC = 4'd0,
    PC_JMP = 4'd1,
    PC_JEZ = 4'd2,
    PC_JNZ = 4'd3,
    PC_JGZ = 4'd4,
    PC_JLZ = 4'd5,
    PC_JRO = 4'd6
  } pc_instr_e;

  typedef enum logic [1:0] {
    ALU_PASS = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_SUB  = 2'd2,
    ALU_NEG  = 2'd3
  } alu_instr_e;

  typedef enum logic [1:0] {
    REG_HOLD      = 2'd0,
    REG_WRITE_ACC = 2'd1,
    REG_SWP       = 2'd2,
    REG_SAV       = 2'd3
  } reg_instr_e;

  typedef enum logic [1:0] {
    SEL_CONST = 2'd0,
    SEL_ACC   = 2'd1,
    SEL_NIL   = 2'd2,
    SEL_PORT  = 2'd3
  } in_sel_e;

  typedef struct packed {
    logic [10:0] cval;
    pc_instr_e   pc;
    alu_instr_e  alu;
    reg_instr_e  regs;
    in_sel_e     in_sel;
    logic        out_sel;
  } dec_t;

  localparam dec_t DEC_NOP = '{
    cval:    11'd0,
    pc:      PC_INC,
    alu:     ALU_PASS,
    regs:    REG_HOLD,
    in_sel:  SEL_NIL,
    out_sel: 1'b0
  };

  function automatic in_sel_e src_sel(input logic [2:0] src);
    in_sel_e s;
    s = SEL_PORT;
    if (src == OPD_IMM) s = SEL_CONST;
    if (src == OPD_ACC) s = SEL_ACC;
    if (src == OPD_NIL) s = SEL_NIL;
    return s;
  endfunction

  function automatic dec_t decode(input logic [20:0] w);
    dec_t d;
    logic [2:0] src;
    logic [2:0] dst;
    d = DEC_NOP;
    d.cval = w[IMM_HI:IMM_LO];
    src = w[SRC_HI:SRC_LO];
    dst = w[DST_HI:DST_LO];
    case (w[OPC_HI:OPC_LO])
      OP_MOV: begin
        d.in_sel = src_sel(src);
        if (dst == OPD_ACC) d.regs = REG_WRITE_ACC;
        // port destinations route the result out instead of into ACC
        if (dst >= OPD_UP) d.out_sel = 1'b1;
      end
      OP_SWP: d.regs = REG_SWP;
      OP_SAV: d.regs = REG_SAV;
      OP_ADD: begin
        d.in_sel = src_sel(src);
        d.alu = ALU_ADD;
        d.regs = REG_WRITE_ACC;
      end
      OP_SUB: begin
        d.in_sel = src_sel(src);
        d.alu = ALU_SUB;
        d.regs = REG_WRITE_ACC;
      end
      OP_NEG: begin
        d.in_sel = SEL_ACC;
        d.alu = ALU_NEG;
        d.regs = REG_WRITE_ACC;
      end
      OP_JMP: d.pc = PC_JMP;
      OP_JEZ: d.pc = PC_JEZ;
      OP_JNZ: d.pc = PC_JNZ;
      OP_JGZ: d.pc = PC_JGZ;
      OP_JLZ: d.pc = PC_JLZ;
      OP_JRO: begin
        d.pc = PC_JRO;
        d.in_sel = src_sel(src);
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/op_decode.sv
// op_decode: registered instruction decoder, one cycle latency.
// Ports: clk, rst (async high), en (stall when low), op_code[20:0] in;
// const_val (signed imm), pc_instr, alu_instr, registers_instr,
// in_mux_sel, out_mux_sel out. const_val carries the "const" field,
// renamed because const is a reserved word.
module op_decode
  import op_decode_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [20:0]        op_code,
  output logic signed [10:0] const_val,
  output logic [3:0]         pc_instr,
  output logic [1:0]         alu_instr,
  output logic [1:0]         registers_instr,
  output logic [1:0]         in_mux_sel,
  output logic               out_mux_sel
);

  dec_t dec_d;
  dec_t dec_q;

  always_comb begin
    dec_d = decode(op_code);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q <= DEC_NOP;
    end else if (en) begin
      dec_q <= dec_d;
    end
  end

  assign const_val       = dec_q.cval;
  assign pc_instr        = dec_q.pc;
  assign alu_instr       = dec_q.alu;
  assign registers_instr = dec_q.regs;
  assign in_mux_sel      = dec_q.in_sel;
  assign out_mux_sel     = dec_q.out_sel;

endmodule

// File: tb/tb_op_decode.sv
// tb_op_decode: scoreboard bench for op_decode with a behavioural
// reference model and random plus directed instruction words.
module tb_op_decode;

  typedef struct packed {
    logic [10:0] c;
    logic [3:0]  pc;
    logic [1:0]  alu;
    logic [1:0]  regs;
    logic [1:0]  insel;
    logic        outs;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               en;
  logic [20:0]        op_code;
  logic signed [10:0] const_val;
  logic [3:0]         pc_instr;
  logic [1:0]         alu_instr;
  logic [1:0]         registers_instr;
  logic [1:0]         in_mux_sel;
  logic               out_mux_sel;

  exp_t q[$];
  exp_t model;
  int   n_checks;
  int   n_pass;

  localparam exp_t RST_EXP = '{c: 11'd0, pc: 4'd0, alu: 2'd0,
                               regs: 2'd0, insel: 2'd2, outs: 1'b0};

  op_decode dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .op_code         (op_code),
    .const_val       (const_val),
    .pc_instr        (pc_instr),
    .alu_instr       (alu_instr),
    .registers_instr (registers_instr),
    .in_mux_sel      (in_mux_sel),
    .out_mux_sel     (out_mux_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t actual();
    exp_t a;
    a = '{c: const_val, pc: pc_instr, alu: alu_instr,
          regs: registers_instr, insel: in_mux_sel, outs: out_mux_sel};
    return a;
  endfunction

  // Reference: table-driven from the instruction-set rules.
  function automatic exp_t ref_model(input logic [20:0] w);
    exp_t e;
    int opc;
    int src;
    int dst;
    int s;
    opc = int'(w[20:17]);
    src = int'(w[16:14]);
    dst = int'(w[13:11]);
    s = (src < 3) ? src : 3;
    e = RST_EXP;
    e.c = w[10:0];
    if (opc == 1) begin
      e.insel = 2'(s);
      e.regs = (dst == 1) ? 2'd1 : 2'd0;
      e.outs = (dst >= 3);
    end else if (opc == 2 || opc == 3) begin
      e.regs = 2'(opc);
    end else if (opc == 4 || opc == 5) begin
      e.insel = 2'(s);
      e.alu = 2'(opc - 3);
      e.regs = 2'd1;
    end else if (opc == 6) begin
      e.alu = 2'd3;
      e.regs = 2'd1;
      e.insel = 2'd1;
    end else if (opc >= 7 && opc <= 11) begin
      e.pc = 4'(opc - 6);
    end else if (opc == 12) begin
      e.pc = 4'd6;
      e.insel = 2'(s);
    end
    return e;
  endfunction

  task automatic check(input string name, input exp_t exp);
    exp_t a;
    a = actual();
    n_checks++;
    if (a === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, a, exp);
  endtask

  task automatic step(input logic e, input logic [20:0] w);
    @(negedge clk);
    en = e;
    op_code = w;
    if (e) model = ref_model(w);
    q.push_back(model);
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst && q.size() > 0) check("scoreboard", q.pop_front());
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    exp_t spec_e;
    n_checks = 0;
    n_pass = 0;
    rst = 1'b1;
    en = 1'b0;
    op_code = '0;
    model = RST_EXP;
    #1;
    check("reset_hold", RST_EXP);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // directed vectors from the instruction examples
    step(1'b1, {4'd1, 3'd0, 3'd1, 11'd5});
    spec_e = '{c: 11'd5, pc: 4'd0, alu: 2'd0, regs: 2'd1,
               insel: 2'd0, outs: 1'b0};
    if (model !== spec_e) $display("FAIL ref_mov: got %h want %h", model, spec_e);
    step(1'b1, {4'd4, 3'd0, 3'd0, 11'h7F9});
    step(1'b1, {4'd1, 3'd1, 3'd4, 11'd0});
    step(1'b1, {4'd10, 3'd0, 3'd0, 11'd3});
    step(1'b1, {4'd12, 3'd3, 3'd0, 11'd0});
    step(1'b1, {4'd15, 3'd5, 3'd6, 11'h4AA});
    step(1'b0, {4'd4, 3'd1, 3'd1, 11'd9});
    step(1'b0, {4'd7, 3'd7, 3'd7, 11'h7FF});
    step(1'b1, {4'd6, 3'd5, 3'd3, 11'h400});
    step(1'b1, {4'd2, 3'd7, 3'd7, 11'd1});
    step(1'b1, {4'd3, 3'd0, 3'd0, 11'd2});
    step(1'b1, {4'd1, 3'd2, 3'd2, 11'd0});

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 8), 21'($urandom));
    end

    // async reset between edges, then reload on the next enabled edge
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", RST_EXP);
    model = RST_EXP;
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, {4'd5, 3'd4, 3'd0, 11'h123});
    step(1'b1, {4'd13, 3'd1, 3'd1, 11'h055});

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d left want 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/op_decode.md
OP_DECODE -- requirements
Module: op_decode

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock; the only clock.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port en, input, 1 bit: decode enable; low holds all outputs (node stall).
REQ-004 SHALL have port op_code, input, 21 bits: instruction word; [20:17] opcode, [16:14] src, [13:11] dst, [10:0] signed immediate or jump target.
REQ-005 SHALL have port const, output, 11 bits signed: immediate or jump target.
REQ-006 SHALL have port pc_instr, output, 4 bits: 0 INC, 1 JMP, 2 JEZ, 3 JNZ, 4 JGZ, 5 JLZ, 6 JRO; 7-15 unused.
REQ-007 SHALL have port alu_instr, output, 2 bits: 0 PASS, 1 ADD, 2 SUB, 3 NEG.
REQ-008 SHALL have port registers_instr, output, 2 bits: 0 HOLD, 1 WRITE_ACC, 2 SWP, 3 SAV.
REQ-009 SHALL have port in_mux_sel, output, 2 bits: 0 const, 1 ACC, 2 NIL (zero), 3 port.
REQ-010 SHALL have port out_mux_sel, output, 1 bit: 1 = result drives the output port, 0 = internal path only.

Function
REQ-011 Opcode SHALL decode as 0 NOP, 1 MOV, 2 SWP, 3 SAV, 4 ADD, 5 SUB, 6 NEG, 7 JMP, 8 JEZ, 9 JNZ, 10 JGZ, 11 JLZ, 12 JRO; 13-15 SHALL decode as NOP.
REQ-012 Operand field codes SHALL be 0 IMM, 1 ACC, 2 NIL, 3 UP, 4 DOWN, 5 LEFT, 6 RIGHT, 7 ANY.
REQ-013 Source mapping for in_mux_sel SHALL be IMM->0, ACC->1, NIL->2, codes 3-7->3.
REQ-014 Outputs SHALL be registered, updating on the rising clk edge when en=1; latency exactly 1 cycle.
REQ-015 const SHALL equal op_code[10:0] for every opcode, bit-exact, no sign manipulation.
REQ-016 Unless a rule below sets a field, the defaults SHALL be pc_instr=0, alu_instr=0, registers_instr=0, in_mux_sel=2, out_mux_sel=0.
REQ-017 For MOV, in_mux_sel SHALL follow src; dst ACC SHALL give registers_instr=1; dst NIL or IMM SHALL give registers_instr=0; dst codes 3-7 SHALL give out_mux_sel=1.
REQ-018 For ADD/SUB, in_mux_sel SHALL follow src, alu_instr SHALL be 1/2, and registers_instr SHALL be 1.
REQ-019 For NEG, alu_instr SHALL be 3, registers_instr 1, and in_mux_sel 1.
REQ-020 SWP and SAV SHALL set registers_instr to 2 and 3 respectively.
REQ-021 JMP/JEZ/JNZ/JGZ/JLZ SHALL set pc_instr 1-5 with in_mux_sel=2; JRO SHALL set pc_instr=6 with in_mux_sel following src.
REQ-022 The src and dst fields SHALL be ignored for opcodes not listed as using them.
REQ-023 With en=0, outputs SHALL hold their previous values regardless of op_code.

Reset
REQ-024 While rst=1, outputs SHALL immediately take the NOP decode: const=0, pc_instr=0, alu_instr=0, registers_instr=0, in_mux_sel=2, out_mux_sel=0.
REQ-025 Reset asserted mid-operation SHALL override en and clk; the first edge after deassertion with en=1 SHALL load the current op_code decode.

Structure
REQ-026 A shared package SHALL hold the opcode, operand, pc_instr, alu_instr, registers_instr and in_mux_sel encodings plus the field bit-position constants.
REQ-027 Implementation SHALL be one combinational decode function/block plus one output register stage; no sub-module is required.

Verification
REQ-028 MOV 5,ACC: op_code {0001,000,001,00000000101} -> next cycle const=5, in_mux_sel=0, registers_instr=1, alu_instr=0, out_mux_sel=0, pc_instr=0.
REQ-029 ADD -7 (opcode 4, src IMM, const 11'h7F9) -> const=-7, alu_instr=1, registers_instr=1, in_mux_sel=0.
REQ-030 MOV ACC,DOWN (opcode 1, src 1, dst 4) -> in_mux_sel=1, out_mux_sel=1, registers_instr=0.
REQ-031 JGZ label 3 (opcode 10, const 3) -> pc_instr=4, const=3, in_mux_sel=2; JRO UP (opcode 12, src 3) -> pc_instr=6, in_mux_sel=3.
REQ-032 Opcode 15 -> NOP decode; en=0 with a new op_code -> outputs unchanged.
REQ-033 Assert rst between edges -> outputs go to reset values without waiting for a clk edge.
